// File: rtl/bp_fpga_host_pkg.sv
// ============================================================================
// bp_fpga_host_pkg : BedRock I/O message types and io_cmd_gen FSM encoding
// Rev 1.0
// ============================================================================
`default_nettype none

package bp_fpga_host_pkg;

    localparam int C_PADDR_WIDTH   = 40;
    localparam int C_DATA_WIDTH    = 64;
    localparam int C_PAYLOAD_WIDTH = 16;

    localparam logic [C_PADDR_WIDTH-1:0] C_PUTCHAR_ADDR = 40'h00_0010_1000;

    typedef enum logic [3:0] {
        e_bedrock_mem_rd    = 4'd0,
        e_bedrock_mem_wr    = 4'd1,
        e_bedrock_mem_uc_rd = 4'd2,
        e_bedrock_mem_uc_wr = 4'd3,
        e_bedrock_mem_pre   = 4'd4,
        e_bedrock_mem_amo   = 4'd5
    } bp_bedrock_mem_type_e;

    typedef enum logic [2:0] {
        e_bedrock_msg_size_1   = 3'd0,
        e_bedrock_msg_size_2   = 3'd1,
        e_bedrock_msg_size_4   = 3'd2,
        e_bedrock_msg_size_8   = 3'd3,
        e_bedrock_msg_size_16  = 3'd4,
        e_bedrock_msg_size_32  = 3'd5,
        e_bedrock_msg_size_64  = 3'd6,
        e_bedrock_msg_size_128 = 3'd7
    } bp_bedrock_msg_size_e;

    typedef struct packed {
        bp_bedrock_mem_type_e mem;
    } bp_bedrock_io_msg_type_s;

    typedef struct packed {
        logic [C_PAYLOAD_WIDTH-1:0] payload;
        bp_bedrock_msg_size_e       size;
        logic [C_PADDR_WIDTH-1:0]   addr;
        bp_bedrock_io_msg_type_s    msg_type;
    } bp_bedrock_io_mem_msg_header_s;

    typedef struct packed {
        bp_bedrock_io_mem_msg_header_s header;
        logic [C_DATA_WIDTH-1:0]       data;
    } bp_bedrock_io_mem_msg_s;

    typedef enum logic [2:0] {
        e_reset = 3'd0,
        e_idle  = 3'd1,
        e_send  = 3'd2,
        e_wait  = 3'd3,
        e_incr  = 3'd4
    } io_cmd_gen_state_e;

    function automatic logic [C_DATA_WIDTH-1:0] fill_bytes(input logic [7:0] b);
        return {(C_DATA_WIDTH/8){b}};
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_fpga_host_io_cmd_gen_sync.sv
// ============================================================================
// bp_fpga_host_io_cmd_gen_sync : button synchronizer + registered rising edge
// Rev 1.0
// ============================================================================
`default_nettype none

module bp_fpga_host_io_cmd_gen_sync #(
    parameter int sync_stages_p = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic send_i,
    output logic rise_o
);

    logic [sync_stages_p-1:0] sync_q;
    logic                     prev_q;
    logic                     rise_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[sync_stages_p-2:0], send_i};
            prev_q <= sync_q[sync_stages_p-1];
            rise_q <= sync_q[sync_stages_p-1] & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

`default_nettype wire

// File: rtl/bp_fpga_host_io_cmd_gen.sv
// ============================================================================
// bp_fpga_host_io_cmd_gen : button-triggered burst of uncached putchar writes
// Optional response checking: BP_FPGA_HOST_IO_CMD_GEN_RESP_CHECK_EN. Rev 1.0
// ============================================================================
`default_nettype none

module bp_fpga_host_io_cmd_gen
    import bp_fpga_host_pkg::*;
#(
    parameter logic [C_PADDR_WIDTH-1:0] putchar_addr_p = C_PUTCHAR_ADDR,
    parameter int                       burst_len_p    = 4,
    parameter int                       sync_stages_p  = 2
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic                   send_i,
    output bp_bedrock_io_mem_msg_s io_cmd_o,
    output logic                   io_cmd_v_o,
    input  logic                   io_cmd_ready_and_i,
    input  bp_bedrock_io_mem_msg_s io_resp_i,
    input  logic                   io_resp_v_i,
    output logic                   io_resp_yumi_o,
    output logic [7:0]             data_byte_o,
    output logic                   busy_o,
    output logic                   error_o
);

    localparam logic [7:0] C_BURST_LAST = 8'(burst_len_p - 1);

    io_cmd_gen_state_e state_q, state_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic [7:0]        data_byte_q, data_byte_d;
    logic              send_rise;

    bp_fpga_host_io_cmd_gen_sync #(
        .sync_stages_p(sync_stages_p)
    ) u_sync (
        .clk_i  (clk_i),
        .reset_i(reset_i),
        .send_i (send_i),
        .rise_o (send_rise)
    );

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q     <= e_reset;
            burst_cnt_q <= '0;
            data_byte_q <= '0;
        end else begin
            state_q     <= state_d;
            burst_cnt_q <= burst_cnt_d;
            data_byte_q <= data_byte_d;
        end
    end

    // Presses outside e_idle are simply never looked at, so they are dropped.
    always_comb begin
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        data_byte_d = data_byte_q;
        io_cmd_v_o  = 1'b0;
        case (state_q)
            e_reset: state_d = e_idle;
            e_idle: begin
                if (send_rise) begin
                    burst_cnt_d = C_BURST_LAST;
                    state_d     = e_send;
                end
            end
            e_send: begin
                io_cmd_v_o = 1'b1;
                if (io_cmd_ready_and_i) begin
                    state_d = e_wait;
                end
            end
            e_wait: begin
                if (io_resp_v_i) begin
                    state_d = e_incr;
                end
            end
            e_incr: begin
                data_byte_d = data_byte_q + 8'd1;
                if (burst_cnt_q == 8'd0) begin
                    state_d = e_idle;
                end else begin
                    burst_cnt_d = burst_cnt_q - 8'd1;
                    state_d     = e_send;
                end
            end
            default: state_d = e_reset;
        endcase
    end

    always_comb begin
        io_cmd_o = '0;
        if (state_q == e_send) begin
            io_cmd_o.header.msg_type.mem = e_bedrock_mem_uc_wr;
            io_cmd_o.header.addr         = putchar_addr_p;
            io_cmd_o.header.size         = e_bedrock_msg_size_1;
            io_cmd_o.data                = fill_bytes(data_byte_q);
        end
    end

    // Every response is drained (even unsolicited ones) so the host cannot stall.
    assign io_resp_yumi_o = io_resp_v_i & (state_q != e_reset);
    assign busy_o         = (state_q != e_reset) && (state_q != e_idle);
    assign data_byte_o    = data_byte_q;

`ifdef BP_FPGA_HOST_IO_CMD_GEN_RESP_CHECK_EN
    logic error_q, error_d, resp_bad;

    always_comb begin
        resp_bad = (io_resp_i.header.msg_type.mem != e_bedrock_mem_uc_wr)
                || (io_resp_i.header.addr != putchar_addr_p)
                || (io_resp_i.header.size != e_bedrock_msg_size_1)
                || (state_q != e_wait);
        error_d  = error_q | (io_resp_yumi_o & resp_bad);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            error_q <= 1'b0;
        end else begin
            error_q <= error_d;
        end
    end

    assign error_o = error_q;
`else
    assign error_o = 1'b0;
`endif

    logic unused_resp;
    assign unused_resp = ^io_resp_i;

endmodule

`default_nettype wire

// File: tb/tb_bp_fpga_host_io_cmd_gen.sv
// ============================================================================
// tb_bp_fpga_host_io_cmd_gen : directed bench with a simple echoing host model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_bp_fpga_host_io_cmd_gen;
    import bp_fpga_host_pkg::*;

    localparam int BURST = 4;
`ifdef BP_FPGA_HOST_IO_CMD_GEN_RESP_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    logic                   clk;
    logic                   reset_i;
    logic                   send_i;
    bp_bedrock_io_mem_msg_s io_cmd_o;
    logic                   io_cmd_v_o;
    logic                   io_cmd_ready_and_i;
    bp_bedrock_io_mem_msg_s io_resp_i;
    logic                   io_resp_v_i;
    logic                   io_resp_yumi_o;
    logic [7:0]             data_byte_o;
    logic                   busy_o;
    logic                   error_o;

    bp_fpga_host_io_cmd_gen #(
        .putchar_addr_p(C_PUTCHAR_ADDR),
        .burst_len_p   (BURST),
        .sync_stages_p (2)
    ) dut (
        .clk_i             (clk),
        .reset_i           (reset_i),
        .send_i            (send_i),
        .io_cmd_o          (io_cmd_o),
        .io_cmd_v_o        (io_cmd_v_o),
        .io_cmd_ready_and_i(io_cmd_ready_and_i),
        .io_resp_i         (io_resp_i),
        .io_resp_v_i       (io_resp_v_i),
        .io_resp_yumi_o    (io_resp_yumi_o),
        .data_byte_o       (data_byte_o),
        .busy_o            (busy_o),
        .error_o           (error_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Host-model knobs and counters
    int                     cmd_total   = 0;
    int                     resp_total  = 0;
    int                     resp_delay  = 0;
    bit                     ready_block = 0;
    bit                     corrupt     = 0;
    bit                     inject_req  = 0;
    bp_bedrock_io_mem_msg_s inject_msg;
    logic [7:0]             exp_byte    = 8'h00;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Host: updates its inputs at negedge, then observes handshakes 1ns later.
    initial begin : host
        bit                            pend;
        int                            pend_wait;
        bp_bedrock_io_mem_msg_s        pend_msg;
        bp_bedrock_io_mem_msg_header_s exp_hdr;
        pend               = 0;
        pend_wait          = 0;
        pend_msg           = '0;
        io_cmd_ready_and_i = 1'b1;
        io_resp_v_i        = 1'b0;
        io_resp_i          = '0;
        forever begin
            @(negedge clk);
            io_cmd_ready_and_i = !ready_block;
            io_resp_v_i        = 1'b0;
            if (reset_i) begin
                pend = 0;
            end else if (inject_req) begin
                io_resp_v_i = 1'b1;
                io_resp_i   = inject_msg;
            end else if (pend && pend_wait == 0) begin
                io_resp_v_i = 1'b1;
                io_resp_i   = pend_msg;
            end else if (pend) begin
                pend_wait--;
            end
            #1;
            if (io_resp_v_i && io_resp_yumi_o) begin
                resp_total++;
                if (inject_req) inject_req = 0;
                else pend = 0;
            end
            if (io_cmd_v_o && io_cmd_ready_and_i && !reset_i) begin
                exp_hdr              = '0;
                exp_hdr.msg_type.mem = e_bedrock_mem_uc_wr;
                exp_hdr.addr         = C_PUTCHAR_ADDR;
                exp_hdr.size         = e_bedrock_msg_size_1;
                chk("cmd_hdr", 128'(io_cmd_o.header), 128'(exp_hdr));
                chk("cmd_data", 128'(io_cmd_o.data), {64'h0, {8{exp_byte}}});
                exp_byte  = exp_byte + 8'd1;
                cmd_total++;
                pend      = 1;
                pend_wait = resp_delay;
                pend_msg  = io_cmd_o;
                if (corrupt) pend_msg.header.addr = io_cmd_o.header.addr + 40'd8;
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "simulation timeout");
    end

    task automatic step();
        @(negedge clk);
        #3;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o && n < 2000) begin
            step();
            n++;
        end
        chk("burst_end", busy_o, 1'b0);
    endtask

    task automatic press_burst();
        int n = 0;
        send_i = 1'b1;
        while (!busy_o && n < 20) begin
            step();
            n++;
        end
        chk("burst_start", busy_o, 1'b1);
        send_i = 1'b0;
        wait_idle();
    endtask

    task automatic do_reset();
        reset_i  = 1'b1;
        exp_byte = 8'h00;
        step();
        step();
        reset_i = 1'b0;
        step();
    endtask

    typedef struct {
        int         delay;
        logic [7:0] exp_data;
        int         exp_cmds;
    } vec_t;

    vec_t vecs[3];

    initial begin : main
        int c0;
        int r0;
        int n;
        bp_bedrock_io_mem_msg_s snap;

        vecs[0] = '{0, 8'h08, BURST};
        vecs[1] = '{3, 8'h0C, BURST};
        vecs[2] = '{1, 8'h10, BURST};

        reset_i    = 1'b1;
        send_i     = 1'b0;
        inject_msg = '0;
        step();
        chk("rst_v", io_cmd_v_o, 1'b0);
        chk("rst_yumi", io_resp_yumi_o, 1'b0);
        chk("rst_busy", busy_o, 1'b0);
        chk("rst_err", error_o, 1'b0);
        chk("rst_data", data_byte_o, 8'h00);
        chk("rst_cmd", 128'(io_cmd_o), 128'h0);
        reset_i = 1'b0;
        step();
        step();

        // Edge latency: 2 sync stages + 1 detect cycle, valid on the 4th edge
        send_i = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            chk("lat_pre", io_cmd_v_o, 1'b0);
        end
        step();
        chk("lat_v", io_cmd_v_o, 1'b1);
        send_i = 1'b0;
        wait_idle();
        chk("b1_cmds", 32'(cmd_total), 32'(BURST));
        chk("b1_data", data_byte_o, 8'h04);
        chk("b1_err", error_o, 1'b0);

        for (int i = 0; i < 3; i++) begin
            resp_delay = vecs[i].delay;
            c0 = cmd_total;
            press_burst();
            chk("vec_cmds", 32'(cmd_total - c0), 32'(vecs[i].exp_cmds));
            chk("vec_data", data_byte_o, vecs[i].exp_data);
            chk("vec_err", error_o, 1'b0);
        end
        resp_delay = 0;

        // Second press while busy must be dropped
        c0 = cmd_total;
        send_i = 1'b1;
        n = 0;
        while (!busy_o && n < 20) begin step(); n++; end
        send_i = 1'b0;
        step();
        step();
        send_i = 1'b1;
        repeat (4) step();
        send_i = 1'b0;
        wait_idle();
        repeat (10) step();
        chk("ign_busy", busy_o, 1'b0);
        chk("ign_cmds", 32'(cmd_total - c0), 32'(BURST));
        chk("ign_data", data_byte_o, 8'h14);

        // Backpressure: valid and fields hold while ready is low
        ready_block = 1;
        c0 = cmd_total;
        send_i = 1'b1;
        n = 0;
        while (!io_cmd_v_o && n < 20) begin step(); n++; end
        send_i = 1'b0;
        snap = io_cmd_o;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_v", io_cmd_v_o, 1'b1);
            chk("bp_stable", 128'(io_cmd_o), 128'(snap));
        end
        chk("bp_none", 32'(cmd_total - c0), 32'd0);
        ready_block = 0;
        step();
        step();
        chk("bp_one", 32'(cmd_total - c0), 32'd1);
        wait_idle();
        chk("bp_cmds", 32'(cmd_total - c0), 32'(BURST));
        chk("bp_data", data_byte_o, 8'h18);

        // Wrap: run until 256 bytes have gone out, byte counter returns to 00
        for (int i = 0; i < 58; i++) press_burst();
        chk("wrap_total", 32'(cmd_total), 32'd256);
        chk("wrap_data", data_byte_o, 8'h00);
        press_burst();
        chk("wrap_next", data_byte_o, 8'h04);
        chk("wrap_err", error_o, 1'b0);

        // Reset while waiting for a response
        resp_delay = 6;
        c0 = cmd_total;
        send_i = 1'b1;
        n = 0;
        while (cmd_total == c0 && n < 20) begin step(); n++; end
        send_i = 1'b0;
        step();
        chk("mid_inwait", {busy_o, io_cmd_v_o}, 2'b10);
        reset_i  = 1'b1;
        exp_byte = 8'h00;
        #1;
        chk("mid_v", io_cmd_v_o, 1'b0);
        chk("mid_busy", busy_o, 1'b0);
        chk("mid_data", data_byte_o, 8'h00);
        step();
        reset_i = 1'b0;
        resp_delay = 0;
        step();
        c0 = cmd_total;
        press_burst();
        chk("mid_restart", data_byte_o, 8'h04);
        chk("mid_cmds", 32'(cmd_total - c0), 32'(BURST));

        // Bad address in responses
        corrupt = 1;
        r0 = resp_total;
        send_i = 1'b1;
        n = 0;
        while (resp_total == r0 && n < 40) begin step(); n++; end
        send_i = 1'b0;
        chk("err_before", error_o, 1'b0);
        step();
        chk("err_after", error_o, EXP_ERR);
        wait_idle();
        corrupt = 0;
        repeat (5) step();
        chk("err_sticky", error_o, EXP_ERR);

        // Unsolicited response while idle
        do_reset();
        chk("err_clr", error_o, 1'b0);
        inject_msg                       = '0;
        inject_msg.header.msg_type.mem   = e_bedrock_mem_uc_wr;
        inject_msg.header.addr           = C_PUTCHAR_ADDR;
        inject_msg.header.size           = e_bedrock_msg_size_1;
        r0 = resp_total;
        inject_req = 1;
        repeat (3) step();
        chk("uns_yumi", 32'(resp_total - r0), 32'd1);
        chk("uns_err", error_o, EXP_ERR);
        chk("uns_busy", busy_o, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/bp_fpga_host_io_cmd_gen.md
# bp_fpga_host_io_cmd_gen

Initiator that drives BedRock I/O commands *into* the FPGA host's inbound I/O port (io_cmd_i / io_resp_o), standing in for the BP core on the board-level bring-up system. On each synchronized rising edge of a push-button, it emits a burst of one-byte uncached writes to the host's putchar address, carrying an incrementing byte, and consumes the matching responses. The host forwards each byte over UART tx.

## Interface
Parameters:
- bp_params_p, e_bp_default_cfg — processor config; supplies paddr_width_p, cce_block_width_p, lce_id_width_p, lce_assoc_p for the io mem-msg struct
- putchar_addr_p, 40'h0010_1000 — destination paddr of every command
- burst_len_p, 4 — commands per button press, 1..255
- sync_stages_p, 2 — send_i synchronizer depth, ≥2

Ports:
- clk_i  in  1  single clock
- reset_i  in  1  asynchronous, active-high reset
- send_i  in  1  asynchronous button level
- io_cmd_o  out  bp_bedrock_io_mem_msg_s  command to host
- io_cmd_v_o  out  1  command valid
- io_cmd_ready_and_i  in  1  host ready; transfer when v & ready_and
- io_resp_i  in  bp_bedrock_io_mem_msg_s  response from host
- io_resp_v_i  in  1  response valid
- io_resp_yumi_o  out  1  response consumed
- data_byte_o  out  8  next byte to be sent
- busy_o  out  1  burst in progress
- error_o  out  1  sticky response-mismatch flag

## Operation
- States: e_reset → e_idle → e_send → e_wait → e_incr → (e_send | e_idle).
- e_reset: entered on reset. Leaves for e_idle after one cycle.
- e_idle: a synchronized rising edge of send_i loads burst_cnt_r = burst_len_p − 1 and moves to e_send. Edges arriving in any other state are dropped, not queued.
- e_send: io_cmd_v_o = 1. Command fields:
  - msg_type.mem = e_bedrock_mem_uc_wr
  - addr = putchar_addr_p
  - size = e_bedrock_msg_size_1
  - payload = '0
  - data = data_byte_r replicated across the full data width
  - Fields are stable while valid is high. On v & ready_and, move to e_wait.
- e_wait: io_resp_yumi_o = io_resp_v_i. When a response is consumed, move to e_incr.
- e_incr: data_byte_r += 1, mod 256, so 8'hFF wraps to 8'h00.
  - If burst_cnt_r == 0, go to e_idle.
  - Otherwise decrement burst_cnt_r and go to e_send.
- A response arriving in any state other than e_wait is still yumi'd, so the host never deadlocks. It flags an error (see Configuration).
- At most one command is outstanding at any time.
- busy_o = (state ∉ {e_reset, e_idle}).
- data_byte_o = data_byte_r.

## Timing
- All outputs reset asynchronously:
  - io_cmd_v_o = 0, io_resp_yumi_o = 0, busy_o = 0, error_o = 0
  - data_byte_o = 8'h00, io_cmd_o = '0
  - State = e_reset; synchronizer and edge flops = 0.
- Edge latency: a send_i change lands at sync output after sync_stages_p clocks. The edge is detected the next cycle, and io_cmd_v_o rises the cycle after that.
- io_cmd_v_o may not depend combinationally on io_cmd_ready_and_i.
- io_resp_yumi_o depends combinationally only on io_resp_v_i and state.
- Minimum per-command cycle: e_send (1) + e_wait (1, if the response is already valid) + e_incr (1) = 3 clocks.
- A response valid in the same cycle the state enters e_wait is consumed that cycle.
- Reset asserted mid-burst drops io_cmd_v_o immediately. The outstanding response, if any, is lost; the host is reset together with this block.
- error_o clears only on reset.

## Configuration
- Macro: BP_FPGA_HOST_IO_CMD_GEN_RESP_CHECK_EN.
- Defined: each consumed response is compared against the command. error_o latches high if any of these hold:
  - msg_type.mem ≠ e_bedrock_mem_uc_wr
  - addr ≠ putchar_addr_p
  - size ≠ e_bedrock_msg_size_1
  - the response arrived outside e_wait
- Undefined: error_o is tied 0 and no comparators or flop are built. Responses are consumed without inspection.

## Structure
- bp_fpga_host_pkg holds io_cmd_gen_state_e (3-bit enum, the five states above).
- The default putchar address constant belongs in the same package.
- Sub-module bp_fpga_host_io_cmd_gen_sync (synchronizer + rising-edge detector, parameter sync_stages_p) is instantiated once.
- The mem-msg struct comes from `declare_bp_bedrock_mem_if(..., io)`.

## Test plan
- **Single burst:** burst_len_p = 4, host ready_and tied 1, response echoed one cycle later; one button press → four uc_wr to putchar_addr_p with data bytes 00, 01, 02, 03; data_byte_o = 04; busy_o drops; error_o = 0.
- **Wrap:** preload by issuing 255 commands, then press once more → byte sequence continues FF, 00, 01; no error.
- **Backpressure:** hold io_cmd_ready_and_i low for 10 cycles during e_send → io_cmd_v_o stays high with stable fields; exactly one command is transferred when ready rises.
- **Ignored press:** assert a second send_i edge while busy_o = 1 → no extra burst; total commands = burst_len_p.
- **Response check (macro defined):** return a response with addr = putchar_addr_p + 8 → error_o = 1 the cycle after yumi and stays high. An unsolicited response in e_idle → yumi'd and error_o = 1. With the macro undefined, the same stimulus → error_o = 0.
- **Reset mid-burst:** assert reset_i in e_wait → io_cmd_v_o = 0, busy_o = 0, data_byte_o = 00 immediately; the next press restarts at 00.
